c64_bus_arbiter: RTL and testbench
==================================

C64_BUS_ARBITER -- requirements
Module: c64_bus_arbiter

Interface
REQ-001 SHALL have parameter ROM_BIT, default 12: bus_addr bit selecting char ROM (1) versus RAM (0).
REQ-002 SHALL have port clk, input, 1: pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port phi0, input, 1: VIC phase clock, 8 clk per period; low = VIC half, high = CPU half.
REQ-005 SHALL have port ba, input, 1: VIC bus-available, low = VIC requests the bus.
REQ-006 SHALL have port vic_ao, input, 14: VIC address.
REQ-007 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, 14) and cpu_wdata (input, 12): CPU access request.
REQ-008 SHALL have port cpu_ack, output, 1: one-clk pulse, access completed; read data valid on the shared data bus.
REQ-009 SHALL have port cpu_rdy, output, 1: registered copy of ba, CPU read-stall indication.
REQ-010 SHALL have port aec, output, 1: 1 = CPU drives the bus.
REQ-011 SHALL have ports bus_addr (output, 14) and bus_wdata (output, 12): shared bus address and write data.
REQ-012 SHALL have ports ram_en, rom_en and ram_we, each output, 1: memory selects and RAM write strobe.

Function
REQ-013 SHALL register phi0 into phi0_q; rise = phi0 & !phi0_q; fall = !phi0 & phi0_q.
REQ-014 SHALL implement states VIC_HALF, CPU_XFER, CPU_NOP and STUN, with a 2-bit ba_cnt that saturates at 3.
REQ-015 On rise: if ba=0 and ba_cnt=3, SHALL go to STUN; otherwise SHALL go to CPU_XFER if a request is accepted, else CPU_NOP.
REQ-016 On rise, ba_cnt SHALL become 0 if ba=1, else min(ba_cnt+1, 3).
REQ-017 On fall, SHALL go to VIC_HALF from any state; STUN is re-evaluated at the next rise and left only when ba=1 is sampled there.
REQ-018 A request is accepted only if cpu_req=1 at rise, and then only if ba=1, or cpu_we=1 and ba_cnt<3; a read with ba=0 is not accepted (the CPU stalls on cpu_rdy).
REQ-019 On acceptance, SHALL latch cpu_addr, cpu_we and cpu_wdata; later changes to cpu_req, cpu_addr or cpu_wdata SHALL not affect the transfer in progress.
REQ-020 aec SHALL be 1 exactly while in state CPU_XFER or CPU_NOP, registered, so the first clk after rise through the fall clk.
REQ-021 bus_addr SHALL be the latched address in CPU_XFER, cpu_addr in CPU_NOP, and vic_ao (combinational) in VIC_HALF and STUN.
REQ-022 bus_wdata SHALL be the latched write data in CPU_XFER and 0 otherwise.
REQ-023 rom_en SHALL equal bus_addr[ROM_BIT]; ram_en SHALL equal !bus_addr[ROM_BIT].
REQ-024 ram_we SHALL assert for exactly one clk, the second clk of CPU_XFER, only for a write with ram_en=1.
REQ-025 A write to the ROM region SHALL produce no ram_we but SHALL still be acknowledged.
REQ-026 cpu_ack SHALL pulse for one clk on the fall that ends CPU_XFER, and at no other time.
REQ-027 SHALL produce at most one accepted transfer per phi0 period.
REQ-028 If rise and fall are both detected in one clk (impossible with legal phi0), fall SHALL take priority.
REQ-029 cpu_rdy SHALL be ba delayed by one clk.

Reset
REQ-030 When rst_n=0 at a clk edge, the next cycle SHALL have: state VIC_HALF, ba_cnt=0, phi0_q=0, aec=0, cpu_ack=0, ram_we=0, cpu_rdy=1, latched address/data 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no cpu_ack and no ram_we.
REQ-032 After reset release, the first rise SHALL be detected no earlier than one clk after phi0_q has sampled phi0=0.

Verification
REQ-033 ba=1, write 0x123 to cpu_addr 0x005 -> aec high 4 clk; ram_we one pulse at 2nd CPU clk with bus_addr=0x005, bus_wdata=0x123; cpu_ack at fall.
REQ-034 Write to 0x1005 (ROM_BIT=12) -> rom_en=1, ram_en=0, no ram_we, cpu_ack pulses.
REQ-035 ba low, back-to-back writes -> 3 writes accepted and acked; 4th rise enters STUN, aec stays 0, bus_addr=vic_ao for whole period.
REQ-036 ba low, read requested -> not accepted, cpu_rdy=0, state CPU_NOP; after ba returns high, next rise accepts the read, cpu_ack at following fall.
REQ-037 rst_n low during 3rd CPU_XFER clk -> aec, ram_we, cpu_ack 0 next clk; state VIC_HALF; no ack for that transfer.
REQ-038 Idle phi0 with cpu_req=0 -> aec toggles 4/4, bus_addr alternates vic_ao / cpu_addr, cpu_ack never asserts.

Source files
------------

// File: rtl/c64_bus_arbiter.sv
// C64-style bus arbiter: shares one memory bus between the VIC (phi0 low half)
// and the CPU (phi0 high half), with BA-driven write grace and CPU stun.
module c64_bus_arbiter #(
  parameter int ROM_BIT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi0,
  input  logic        ba,
  input  logic [13:0] vic_ao,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rdy,
  output logic        aec,
  output logic [13:0] bus_addr,
  output logic [11:0] bus_wdata,
  output logic        ram_en,
  output logic        rom_en,
  output logic        ram_we
);

  typedef enum logic [1:0] {
    VIC_HALF = 2'd0,
    CPU_XFER = 2'd1,
    CPU_NOP  = 2'd2,
    STUN     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_phi0_q;
  logic        r_phi0_armed;
  logic [1:0]  r_ba_cnt;
  logic [1:0]  w_ba_cnt_next;
  logic [1:0]  r_xfer_cnt;
  logic        r_we;
  logic [13:0] r_addr;
  logic [11:0] r_wdata;
  logic        r_cpu_rdy;

  logic w_rise;
  logic w_fall;
  logic w_stun;
  logic w_accept;
  logic w_take;

  // A rise only counts once phi0_q holds a genuinely sampled low, so a phi0
  // that is already high when reset releases does not open a CPU half.
  assign w_rise   = phi0 & ~r_phi0_q & r_phi0_armed;
  assign w_fall   = ~phi0 & r_phi0_q;
  assign w_stun   = ~ba & (r_ba_cnt == 2'd3);
  assign w_accept = cpu_req & (ba | (cpu_we & (r_ba_cnt != 2'd3)));
  assign w_take   = w_rise & ~w_fall & ~w_stun & w_accept;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_ba_cnt_next = r_ba_cnt;
    if (w_fall) begin
      w_next_state = VIC_HALF;
    end else if (w_rise) begin
      if (w_stun)        w_next_state = STUN;
      else if (w_accept) w_next_state = CPU_XFER;
      else               w_next_state = CPU_NOP;
      if (ba)                     w_ba_cnt_next = 2'd0;
      else if (r_ba_cnt != 2'd3)  w_ba_cnt_next = r_ba_cnt + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= VIC_HALF;
      r_phi0_q     <= 1'b0;
      r_phi0_armed <= 1'b0;
      r_ba_cnt     <= 2'd0;
      r_xfer_cnt   <= 2'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdy    <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_phi0_q  <= phi0;
      r_ba_cnt  <= w_ba_cnt_next;
      r_cpu_rdy <= ba;
      if (!phi0) r_phi0_armed <= 1'b1;
      if (w_take) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (w_rise)
        r_xfer_cnt <= 2'd0;
      else if (r_state == CPU_XFER && r_xfer_cnt != 2'd3)
        r_xfer_cnt <= r_xfer_cnt + 2'd1;
    end
  end

  always_comb begin
    bus_addr  = vic_ao;
    bus_wdata = '0;
    case (r_state)
      CPU_XFER: begin
        bus_addr  = r_addr;
        bus_wdata = r_wdata;
      end
      CPU_NOP:  bus_addr = cpu_addr;
      default:  bus_addr = vic_ao;
    endcase
  end

  assign aec     = (r_state == CPU_XFER) | (r_state == CPU_NOP);
  assign rom_en  = bus_addr[ROM_BIT];
  assign ram_en  = ~bus_addr[ROM_BIT];
  assign cpu_rdy = r_cpu_rdy;

  // Strobes are gated by rst_n so a transfer caught by reset never completes.
  assign ram_we  = rst_n & (r_state == CPU_XFER) & (r_xfer_cnt == 2'd1) & r_we & ram_en;
  assign cpu_ack = rst_n & (r_state == CPU_XFER) & w_fall;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Self-checking bench for c64_bus_arbiter: per-phi0-period reference model
// with randomized bus traffic, BA patterns and mid-transfer reset.
module tb_c64_bus_arbiter;

  localparam int ROM_BIT = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phi0 = 1'b0;
  logic        ba = 1'b0;
  logic [13:0] vic_ao = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_rdy, aec, ram_en, rom_en, ram_we;
  logic [13:0] bus_addr;
  logic [11:0] bus_wdata;

  int checks = 0;
  int errors = 0;
  int m_ba_cnt = 0;      // model of the BA-low rise counter (saturating at 3)
  logic exp_rdy;         // expected cpu_rdy for the current interval

  c64_bus_arbiter #(.ROM_BIT(ROM_BIT)) dut (
    .clk(clk), .rst_n(rst_n), .phi0(phi0), .ba(ba), .vic_ao(vic_ao),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdy(cpu_rdy), .aec(aec), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .ram_en(ram_en), .rom_en(rom_en), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // Wait for the next edge; cpu_rdy then shows the ba seen at that edge.
  task automatic next_interval();
    @(posedge clk);
    exp_rdy = rst_n ? ba : 1'b1;
    #1;
  endtask

  // One phi0 period: phi0 high in intervals 0..3, low in 4..7. The rise is
  // sampled at the edge ending interval 0; the CPU owns intervals 1..4.
  task automatic run_period(input logic i_req, input logic i_we, input logic [13:0] i_addr,
                            input logic [11:0] i_wd, input logic i_ba, input bit rand_ba,
                            input int rst_at, output int n_aec, output int n_we,
                            output int n_ack, output bit vic_only);
    bit m_xfer, m_nop, m_stun, reset_seen, cpu;
    logic [13:0] e_addr;
    logic [11:0] e_wd;
    logic e_we, e_ack;
    n_aec = 0; n_we = 0; n_ack = 0; vic_only = 1'b1;
    m_xfer = 1'b0; m_nop = 1'b0; reset_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_interval();
      if (k == 1) begin
        m_stun = !i_ba && m_ba_cnt == 3;
        m_xfer = !m_stun && i_req && (i_ba || (i_we && m_ba_cnt < 3));
        m_nop  = !m_stun && !m_xfer;
        m_ba_cnt = i_ba ? 0 : (m_ba_cnt < 3 ? m_ba_cnt + 1 : 3);
      end
      if (rst_at >= 0 && k == rst_at + 1) begin
        reset_seen = 1'b1;
        m_ba_cnt = 0;
      end
      phi0   = (k < 4);
      rst_n  = (k == rst_at) ? 1'b0 : 1'b1;
      vic_ao = 14'($urandom);
      if (k == 0) begin
        cpu_req = i_req; cpu_we = i_we; cpu_addr = i_addr; cpu_wdata = i_wd; ba = i_ba;
      end else begin
        cpu_req   = 1'($urandom);
        cpu_we    = 1'($urandom);
        cpu_addr  = 14'($urandom);
        cpu_wdata = 12'($urandom);
        ba        = rand_ba ? 1'($urandom) : i_ba;
      end
      cpu    = !reset_seen && k >= 1 && k <= 4 && (m_xfer || m_nop);
      e_addr = !cpu ? vic_ao : (m_xfer ? i_addr : cpu_addr);
      e_wd   = (cpu && m_xfer) ? i_wd : 12'h000;
      e_we   = cpu && m_xfer && k == 2 && i_we && !i_addr[ROM_BIT] && rst_n;
      e_ack  = cpu && m_xfer && k == 4 && rst_n;
      #3;
      checks++;
      if (aec !== cpu) begin
        errors++; $display("FAIL aec k=%0d got %b want %b", k, aec, cpu);
      end
      checks++;
      if (bus_addr !== e_addr) begin
        errors++; $display("FAIL bus_addr k=%0d got %h want %h", k, bus_addr, e_addr);
      end
      checks++;
      if (bus_wdata !== e_wd) begin
        errors++; $display("FAIL bus_wdata k=%0d got %h want %h", k, bus_wdata, e_wd);
      end
      checks++;
      if (ram_we !== e_we) begin
        errors++; $display("FAIL ram_we k=%0d got %b want %b", k, ram_we, e_we);
      end
      checks++;
      if (cpu_ack !== e_ack) begin
        errors++; $display("FAIL cpu_ack k=%0d got %b want %b", k, cpu_ack, e_ack);
      end
      checks++;
      if (rom_en !== e_addr[ROM_BIT] || ram_en !== !e_addr[ROM_BIT]) begin
        errors++; $display("FAIL mem_sel k=%0d got rom=%b ram=%b addr=%h", k, rom_en, ram_en, e_addr);
      end
      checks++;
      if (cpu_rdy !== exp_rdy) begin
        errors++; $display("FAIL cpu_rdy k=%0d got %b want %b", k, cpu_rdy, exp_rdy);
      end
      if (aec === 1'b1) n_aec++;
      if (ram_we === 1'b1) n_we++;
      if (cpu_ack === 1'b1) n_ack++;
      if (bus_addr !== vic_ao) vic_only = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phi0 = 1'b0; ba = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_interval();
      vic_ao = 14'($urandom);
      #3;
      checks++;
      if (aec !== 1'b0 || cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
        errors++; $display("FAIL reset_strobes got aec=%b ack=%b we=%b want 0", aec, cpu_ack, ram_we);
      end
      checks++;
      if (cpu_rdy !== 1'b1) begin
        errors++; $display("FAIL reset_rdy got %b want 1", cpu_rdy);
      end
      checks++;
      if (bus_addr !== vic_ao || bus_wdata !== 12'h000) begin
        errors++; $display("FAIL reset_bus got %h/%h want %h/000", bus_addr, bus_wdata, vic_ao);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_interval();
      ba = 1'b1;
      #3;
      checks++;
      if (aec !== 1'b0 || cpu_rdy !== exp_rdy) begin
        errors++; $display("FAIL post_reset got aec=%b rdy=%b want 0/%b", aec, cpu_rdy, exp_rdy);
      end
    end
    m_ba_cnt = 0;
  endtask

  // phi0 already high at reset release must not be seen as a rise.
  task automatic test_reset_phi0_high();
    next_interval();
    rst_n = 1'b0; phi0 = 1'b1; ba = 1'b1;
    next_interval();
    next_interval();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_interval();
      phi0 = (i < 3);
      #3;
      checks++;
      if (aec !== 1'b0) begin
        errors++; $display("FAIL no_false_rise i=%0d got aec=%b want 0", i, aec);
      end
    end
    m_ba_cnt = 0;
  endtask

  task automatic test_single_write();
    int a, w, c; bit v;
    run_period(1'b1, 1'b1, 14'h0005, 12'h123, 1'b1, 1'b0, -1, a, w, c, v);
    checks++;
    if (a != 4 || w != 1 || c != 1) begin
      errors++; $display("FAIL single_write got aec=%0d we=%0d ack=%0d want 4/1/1", a, w, c);
    end
  endtask

  task automatic test_rom_write();
    int a, w, c; bit v;
    run_period(1'b1, 1'b1, 14'h1005, 12'h0AB, 1'b1, 1'b0, -1, a, w, c, v);
    checks++;
    if (w != 0 || c != 1) begin
      errors++; $display("FAIL rom_write got we=%0d ack=%0d want 0/1", w, c);
    end
  endtask

  task automatic test_stun();
    int a, w, c; bit v;
    run_period(1'b0, 1'b0, 14'h0000, 12'h000, 1'b1, 1'b0, -1, a, w, c, v);
    for (int p = 0; p < 3; p++) begin
      run_period(1'b1, 1'b1, 14'(16 + p), 12'(12'h300 + p), 1'b0, 1'b0, -1, a, w, c, v);
      checks++;
      if (c != 1 || w != 1) begin
        errors++; $display("FAIL stun_grace p=%0d got ack=%0d we=%0d want 1/1", p, c, w);
      end
    end
    run_period(1'b1, 1'b1, 14'h0040, 12'h444, 1'b0, 1'b0, -1, a, w, c, v);
    checks++;
    if (a != 0 || c != 0 || !v) begin
      errors++; $display("FAIL stun got aec=%0d ack=%0d vic_only=%b want 0/0/1", a, c, v);
    end
    run_period(1'b1, 1'b1, 14'h0041, 12'h555, 1'b1, 1'b0, -1, a, w, c, v);
    checks++;
    if (a != 4 || c != 1) begin
      errors++; $display("FAIL stun_exit got aec=%0d ack=%0d want 4/1", a, c);
    end
  endtask

  task automatic test_read_stall();
    int a, w, c; bit v;
    run_period(1'b0, 1'b0, 14'h0000, 12'h000, 1'b1, 1'b0, -1, a, w, c, v);
    run_period(1'b1, 1'b0, 14'h0077, 12'h000, 1'b0, 1'b0, -1, a, w, c, v);
    checks++;
    if (a != 4 || c != 0) begin
      errors++; $display("FAIL read_stall got aec=%0d ack=%0d want 4/0", a, c);
    end
    run_period(1'b1, 1'b0, 14'h0077, 12'h000, 1'b1, 1'b0, -1, a, w, c, v);
    checks++;
    if (c != 1 || w != 0) begin
      errors++; $display("FAIL read_resume got ack=%0d we=%0d want 1/0", c, w);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int a, w, c; bit v;
    run_period(1'b1, 1'b1, 14'h0123, 12'hABC, 1'b1, 1'b0, 3, a, w, c, v);
    checks++;
    if (c != 0 || a != 3) begin
      errors++; $display("FAIL reset_mid_xfer got ack=%0d aec=%0d want 0/3", c, a);
    end
    run_period(1'b1, 1'b1, 14'h0124, 12'h0DE, 1'b1, 1'b0, -1, a, w, c, v);
    checks++;
    if (c != 1 || w != 1) begin
      errors++; $display("FAIL after_reset got ack=%0d we=%0d want 1/1", c, w);
    end
  endtask

  task automatic test_idle();
    int a, w, c; bit v;
    for (int p = 0; p < 2; p++) begin
      run_period(1'b0, 1'b0, 14'($urandom), 12'h000, 1'b1, 1'b1, -1, a, w, c, v);
      checks++;
      if (a != 4 || c != 0 || w != 0) begin
        errors++; $display("FAIL idle p=%0d got aec=%0d ack=%0d we=%0d want 4/0/0", p, a, c, w);
      end
    end
  endtask

  task automatic test_random();
    int a, w, c; bit v;
    for (int p = 0; p < 40; p++) begin
      run_period(1'($urandom), 1'($urandom), 14'($urandom), 12'($urandom),
                 ($urandom_range(0, 2) != 0), 1'b1, -1, a, w, c, v);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rom_write();
    test_stun();
    test_read_stall();
    test_reset_mid_xfer();
    test_idle();
    test_random();
    test_reset_phi0_high();
    test_single_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
